compare_unit: RTL and testbench

COMPARE_UNIT -- requirements
Module: compare_unit

---
 rtl/compare_unit.sv | 93 +++++++++
 tb/tb_compare_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/compare_unit.sv
// rtl/compare_unit.sv - multi-cycle magnitude comparator, one chunk per cycle from the MSB end
module compare_unit #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [2:0]       c
);

    // Guarded chunk size so the derived constants stay computable even when
    // the parameter check below is about to stop elaboration.
    localparam int CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
    localparam int NCHUNK     = WIDTH / CHUNK_SAFE;
    localparam int IDXW       = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [IDXW-1:0]  TOP_IDX  = IDXW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    generate
        if ((CHUNK < 1) || (WIDTH < 1) || ((WIDTH % CHUNK_SAFE) != 0)) begin : g_bad_params
            $error("compare_unit: WIDTH must be a positive multiple of CHUNK and CHUNK >= 1");
        end
    endgenerate

    logic [0:0]       state;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [CHUNK_SAFE-1:0] chunk_a;
    logic [CHUNK_SAFE-1:0] chunk_b;

    // Current chunk of each captured operand, selected by the chunk index.
    assign chunk_a = CHUNK_SAFE'(ra >> (int'(idx) * CHUNK_SAFE));
    assign chunk_b = CHUNK_SAFE'(rb >> (int'(idx) * CHUNK_SAFE));

    assign busy = (state == BUSY);

    // Capture on start, then walk chunks MSB-first; the first differing chunk
    // decides the result, so equal operands run the full NCHUNK cycles.
    // Signed mode flips the sign bits at capture, which maps two's-complement
    // order onto unsigned order for the whole chunk walk.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            ra    <= '0;
            rb    <= '0;
            c     <= 3'b000;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ra    <= mode_signed ? (a ^ MSB_MASK) : a;
                        rb    <= mode_signed ? (b ^ MSB_MASK) : b;
                        idx   <= TOP_IDX;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (chunk_a > chunk_b) begin
                        c     <= 3'b001;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else if (chunk_a < chunk_b) begin
                        c     <= 3'b010;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else if (idx != '0) begin
                        idx <= idx - 1'b1;
                    end else begin
                        c     <= 3'b100;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_compare_unit.sv
// tb/tb_compare_unit.sv - directed and randomized checks of compare_unit against a reference model
module tb_compare_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        ms;
    logic [31:0] ia;
    logic [31:0] ib;
    logic        busy;
    logic        done;
    logic [2:0]  c;

    logic        start2;
    logic        ms2;
    logic [15:0] a2;
    logic [15:0] b2;
    logic        busy2;
    logic        done2;
    logic [2:0]  c2;

    int vectors;
    int miscompares;

    compare_unit #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst(rst), .start(start), .mode_signed(ms),
        .a(ia), .b(ib), .busy(busy), .done(done), .c(c)
    );

    compare_unit #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk(clk), .rst(rst), .start(start2), .mode_signed(ms2),
        .a(a2), .b(b2), .busy(busy2), .done(done2), .c(c2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: ordering from plain integer compare, latency from the
    // position of the most significant differing bit.
    function automatic logic [2:0] ref_c(input logic [31:0] x, input logic [31:0] y, input logic s);
        if (x == y) return 3'b100;
        if (s) return ($signed(x) > $signed(y)) ? 3'b001 : 3'b010;
        return (x > y) ? 3'b001 : 3'b010;
    endfunction

    function automatic int ref_lat(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] d;
        d = x ^ y;
        for (int i = 31; i >= 0; i--) begin
            if (d[i]) return 4 - i / 8;
        end
        return 4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic s);
        ia    = x;
        ib    = y;
        ms    = s;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input int already, output int lat);
        lat = already;
        do begin
            tick();
            lat++;
        end while (!done && lat < 12);
    endtask

    task automatic run_full(input logic [31:0] x, input logic [31:0] y, input logic s,
                            output int lat, output logic [2:0] res);
        start_op(x, y, s);
        wait_done(0, lat);
        res = c;
        chk("latency", 32'(lat), 32'(ref_lat(x, y)));
        chk("result", 32'(c), 32'(ref_c(x, y, s)));
        chk("busy_at_done", 32'(busy), 32'd0);
        tick();
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("c_hold", 32'(c), 32'(res));
    endtask

    initial begin
        int          lat;
        int          seen;
        int          pos;
        logic [2:0]  res;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] m;

        vectors     = 0;
        miscompares = 0;
        rst    = 1'b1;
        start  = 1'b0;
        ms     = 1'b0;
        ia     = '0;
        ib     = '0;
        start2 = 1'b0;
        ms2    = 1'b0;
        a2     = '0;
        b2     = '0;
        tick();
        tick();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_c", 32'(c), 32'd0);
        chk("reset16_busy", 32'(busy2), 32'd0);
        rst = 1'b0;

        // Unsigned and signed on a sign-boundary pair: decided in the MSB chunk.
        run_full(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, lat, res);
        chk("uns_msb_lat", 32'(lat), 32'd1);
        chk("uns_msb_c", 32'(res), 32'b001);
        run_full(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, lat, res);
        chk("sgn_msb_lat", 32'(lat), 32'd1);
        chk("sgn_msb_c", 32'(res), 32'b010);

        // Equal operands take every chunk.
        run_full(32'h1234_5678, 32'h1234_5678, 1'b0, lat, res);
        chk("eq_lat", 32'(lat), 32'd4);
        chk("eq_c", 32'(res), 32'b100);

        // LSB-chunk difference with operand change and stray start while busy.
        start_op(32'h0000_00FF, 32'h0000_00FE, 1'b0);
        ia    = 32'h0000_0000;
        ms    = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("lsb_still_busy", 32'(busy), 32'd1);
        wait_done(1, lat);
        chk("lsb_lat", 32'(lat), 32'd4);
        chk("lsb_c", 32'(c), 32'b001);

        // Back-to-back: start held high across the done cycle.
        tick();
        start_op(32'h1234_5678, 32'h1234_5678, 1'b0);
        tick();
        tick();
        ia    = 32'd1;
        ib    = 32'd2;
        ms    = 1'b0;
        start = 1'b1;
        tick();
        chk("b2b_no_early_done", 32'(done), 32'd0);
        wait_done(3, lat);
        chk("b2b_first_lat", 32'(lat), 32'd4);
        chk("b2b_first_c", 32'(c), 32'b100);
        tick();
        start = 1'b0;
        chk("b2b_no_bubble_busy", 32'(busy), 32'd1);
        chk("b2b_no_bubble_done", 32'(done), 32'd0);
        wait_done(0, lat);
        chk("b2b_second_lat", 32'(lat), 32'd4);
        chk("b2b_second_c", 32'(c), 32'b010);

        // Reset in the second busy cycle of an equal compare.
        tick();
        start_op(32'hCAFE_BABE, 32'hCAFE_BABE, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        chk("rst_mid_c", 32'(c), 32'd0);
        seen = 0;
        repeat (6) begin
            tick();
            if (done) seen++;
        end
        chk("rst_no_done", 32'(seen), 32'd0);

        // Start accepted on the first edge after reset drops.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run_full(32'h0000_0100, 32'h0000_0200, 1'b0, lat, res);
        chk("post_rst_lat", 32'(lat), 32'd3);
        chk("post_rst_c", 32'(res), 32'b010);

        // Single full-width chunk instance.
        a2     = 16'hFFFF;
        b2     = 16'h0001;
        ms2    = 1'b1;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("w16_busy", 32'(busy2), 32'd1);
        tick();
        chk("w16_sgn_done", 32'(done2), 32'd1);
        chk("w16_sgn_c", 32'(c2), 32'b010);
        ms2    = 1'b0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        tick();
        chk("w16_uns_done", 32'(done2), 32'd1);
        chk("w16_uns_c", 32'(c2), 32'b001);

        // Randomized operands with the first difference placed at a random bit.
        for (int i = 0; i < 40; i++) begin
            x   = $urandom;
            pos = $urandom_range(0, 32);
            if (pos == 32) begin
                y = x;
            end else begin
                m = 32'h1 << pos;
                y = x ^ m ^ ($urandom & (m - 32'h1));
            end
            run_full(x, y, 1'($urandom_range(0, 1)), lat, res);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
